// File: rtl/doodle_physics_if.sv
`default_nettype none
// ============================================================================
// doodle_physics_if : run-time write port for the doodle_physics platform table
// Revision          : 1.0
// ============================================================================
interface doodle_physics_if #(
   parameter int NUM_PLAT = 16,
   parameter int COORD_W  = 16
);
   logic                        plat_we;
   logic [$clog2(NUM_PLAT)-1:0] plat_idx;
   logic [COORD_W-1:0]          plat_x;
   logic [COORD_W-1:0]          plat_y;
   logic                        plat_valid;

   modport master (output plat_we, plat_idx, plat_x, plat_y, plat_valid);
   modport slave  (input  plat_we, plat_idx, plat_x, plat_y, plat_valid);
endinterface
`default_nettype wire

// File: rtl/doodle_physics.sv
`default_nettype none
// ============================================================================
// doodle_physics : doodle jump cycle, scroll/score keeping and platform scanner
// Revision       : 1.0
// ============================================================================
module doodle_physics #(
   parameter int NUM_PLAT    = 16,
   parameter int COORD_W     = 16,
   parameter int JUMP_HEIGHT = 120,
   parameter int START_Y     = 400,
   parameter int V_MIDDLE    = 275,
   parameter int FLOOR_Y     = 515,
   parameter int DOODLE_R    = 13,
   parameter int PLAT_RW     = 32,
   parameter int PLAT_RH     = 7
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        Start,
   input  logic                        Ack,
   input  logic                        frame_tick,
   input  logic [3:0]                  speed,
   input  logic [COORD_W-1:0]          doodle_x,
   doodle_physics_if.slave             tbl,
   output logic                        q_I,
   output logic                        q_Up,
   output logic                        q_Down,
   output logic                        q_Done,
   output logic [COORD_W-1:0]          doodle_y,
   output logic [COORD_W-1:0]          scroll,
   output logic [COORD_W-1:0]          score,
   output logic                        is_in_middle,
   output logic                        busy,
   output logic [$clog2(NUM_PLAT)-1:0] hit_idx
);
   localparam int IDX_W = $clog2(NUM_PLAT);
   localparam int XW    = COORD_W + 2;

   localparam logic [COORD_W-1:0]   c_start_y  = COORD_W'(START_Y);
   localparam logic [COORD_W-1:0]   c_v_middle = COORD_W'(V_MIDDLE);
   localparam logic [COORD_W-1:0]   c_jump     = COORD_W'(JUMP_HEIGHT);
   localparam logic signed [XW-1:0] c_floor    = XW'(FLOOR_Y);
   localparam logic signed [XW-1:0] c_r        = XW'(DOODLE_R);
   localparam logic signed [XW-1:0] c_reach    = XW'(DOODLE_R + PLAT_RW);
   localparam logic signed [XW-1:0] c_rh       = XW'(PLAT_RH);
   localparam logic [IDX_W-1:0]     c_last_idx = IDX_W'(NUM_PLAT - 1);
   localparam logic [IDX_W-1:0]     c_idx_one  = IDX_W'(1);

   typedef enum logic [3:0] {
      S_I    = 4'b0001,
      S_UP   = 4'b0010,
      S_DOWN = 4'b0100,
      S_DONE = 4'b1000
   } state_t;

   state_t               state_q;
   logic [COORD_W-1:0]   doodle_y_q, scroll_q, score_q, up_count_q;
   logic                 mid_q, busy_q;
   logic [IDX_W-1:0]     scan_idx_q, hit_idx_q;
   logic [NUM_PLAT-1:0]  valid_q;
   logic [COORD_W-1:0]   plat_x_q [NUM_PLAT];
   logic [COORD_W-1:0]   plat_y_q [NUM_PLAT];

   logic [COORD_W-1:0]   w_spd;
   logic [COORD_W-1:0]   up_count_d, y_down_d, score_d, scroll_d;
   logic [COORD_W:0]     w_score_sum, w_scroll_sum;
   logic signed [XW-1:0] w_dx, w_top, w_feet, w_feet_down;
   logic                 w_hit, w_falls;

   assign w_spd        = COORD_W'(speed);
   assign up_count_d   = up_count_q + w_spd;
   assign y_down_d     = doodle_y_q + w_spd;
   assign w_score_sum  = {1'b0, score_q} + {1'b0, w_spd};
   assign w_scroll_sum = {1'b0, scroll_q} + {1'b0, w_spd};
   assign score_d      = w_score_sum[COORD_W]  ? '1 : w_score_sum[COORD_W-1:0];
   assign scroll_d     = w_scroll_sum[COORD_W] ? '1 : w_scroll_sum[COORD_W-1:0];

   assign w_feet_down  = $signed({2'b00, y_down_d}) + c_r;
   assign w_falls      = w_feet_down > c_floor;

   // Platform y is a signed world coordinate; everything else is zero-extended.
   assign w_dx   = $signed({2'b00, doodle_x}) - $signed({2'b00, plat_x_q[scan_idx_q]});
   assign w_top  = $signed({{2{plat_y_q[scan_idx_q][COORD_W-1]}}, plat_y_q[scan_idx_q]})
                 + $signed({2'b00, scroll_q});
   assign w_feet = $signed({2'b00, doodle_y_q}) + c_r;
   assign w_hit  = valid_q[scan_idx_q]
                 && (w_dx <= c_reach) && (w_dx >= -c_reach)
                 && (w_feet >= w_top - c_rh) && (w_feet <= w_top + c_rh);

   always_ff @(posedge Clk) begin
      if (tbl.plat_we) begin
         plat_x_q[tbl.plat_idx] <= tbl.plat_x;
         plat_y_q[tbl.plat_idx] <= tbl.plat_y;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         valid_q <= '0;
      end else if (tbl.plat_we) begin
         valid_q[tbl.plat_idx] <= tbl.plat_valid;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_I;
         doodle_y_q <= c_start_y;
         scroll_q   <= '0;
         score_q    <= '0;
         up_count_q <= '0;
         mid_q      <= 1'b0;
         busy_q     <= 1'b0;
         scan_idx_q <= '0;
         hit_idx_q  <= '0;
      end else begin
         unique case (state_q)
            S_I: begin
               if (Start) begin
                  state_q    <= S_UP;
                  up_count_q <= '0;
               end
            end
            S_UP: begin
               if (frame_tick) begin
                  score_q <= score_d;
                  if (doodle_y_q <= c_v_middle) begin
                     scroll_q <= scroll_d;
                     mid_q    <= 1'b1;
                  end else begin
                     doodle_y_q <= doodle_y_q - w_spd;
                     mid_q      <= 1'b0;
                  end
                  if (up_count_d >= c_jump) begin
                     state_q    <= S_DOWN;
                     up_count_q <= '0;
                  end else begin
                     up_count_q <= up_count_d;
                  end
               end
            end
            S_DOWN: begin
               // Ticks arriving mid-scan are dropped rather than queued.
               if (busy_q) begin
                  if (w_hit) begin
                     state_q    <= S_UP;
                     hit_idx_q  <= scan_idx_q;
                     busy_q     <= 1'b0;
                     up_count_q <= '0;
                  end else if (scan_idx_q == c_last_idx) begin
                     busy_q <= 1'b0;
                  end else begin
                     scan_idx_q <= scan_idx_q + c_idx_one;
                  end
               end else if (frame_tick) begin
                  doodle_y_q <= y_down_d;
                  if (w_falls) begin
                     state_q <= S_DONE;
                  end else begin
                     busy_q     <= 1'b1;
                     scan_idx_q <= '0;
                  end
               end
            end
            S_DONE: begin
               if (Ack) begin
                  state_q    <= S_I;
                  doodle_y_q <= c_start_y;
                  scroll_q   <= '0;
                  score_q    <= '0;
                  mid_q      <= 1'b0;
               end
            end
            default: state_q <= S_I;
         endcase
      end
   end

   assign q_I          = (state_q == S_I);
   assign q_Up         = (state_q == S_UP);
   assign q_Down       = (state_q == S_DOWN);
   assign q_Done       = (state_q == S_DONE);
   assign doodle_y     = doodle_y_q;
   assign scroll       = scroll_q;
   assign score        = score_q;
   assign is_in_middle = mid_q;
   assign busy         = busy_q;
   assign hit_idx      = hit_idx_q;
endmodule
`default_nettype wire

// File: tb/tb_doodle_physics.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_doodle_physics : scoreboard bench, directed scenarios plus random play
// Revision          : 1.0
// ============================================================================
module tb_doodle_physics;
   localparam int NP = 4;
   localparam int W  = 16;

   logic         Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Ack = 1'b0, frame_tick = 1'b0;
   logic [3:0]   speed = 4'd4;
   logic [W-1:0] doodle_x = 16'd300;
   logic         q_I, q_Up, q_Down, q_Done, is_in_middle, busy;
   logic [W-1:0] doodle_y, scroll, score;
   logic [1:0]   hit_idx;

   doodle_physics_if #(.NUM_PLAT(NP), .COORD_W(W)) tbl ();

   doodle_physics #(.NUM_PLAT(NP), .COORD_W(W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .frame_tick(frame_tick),
      .speed(speed), .doodle_x(doodle_x), .tbl(tbl),
      .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done),
      .doodle_y(doodle_y), .scroll(scroll), .score(score),
      .is_in_middle(is_in_middle), .busy(busy), .hit_idx(hit_idx)
   );

   always #5 Clk = ~Clk;

   // Reference game state: 0=I 1=UP 2=DOWN 3=DONE
   int m_st, m_y, m_scroll, m_score, m_up, m_mid, m_busy, m_hit;
   int tx [NP];
   int ty [NP];
   int tv [NP];

   typedef struct {
      int stamp; int st; int y; int scr; int sco; int mid; int busy; int hit;
   } exp_t;
   exp_t  sb  [$];
   string sbn [$];
   exp_t  ex;
   string exn;
   int    cyc = 0, n_vec = 0, n_bad = 0;
   logic [3:0] got_st;

   function automatic void push(string nm, int stamp);
      exp_t e;
      e.stamp = stamp; e.st = m_st; e.y = m_y; e.scr = m_scroll; e.sco = m_score;
      e.mid = m_mid; e.busy = m_busy; e.hit = m_hit;
      sb.push_back(e);
      sbn.push_back(nm);
   endfunction

   function automatic void model_reset();
      m_st = 0; m_y = 400; m_scroll = 0; m_score = 0; m_up = 0;
      m_mid = 0; m_busy = 0; m_hit = 0;
      for (int i = 0; i < NP; i++) tv[i] = 0;
   endfunction

   function automatic int first_hit();
      int feet, dx, top;
      feet = m_y + 13;
      for (int i = 0; i < NP; i++) begin
         dx  = int'(doodle_x) - tx[i];
         top = ty[i] + m_scroll;
         if (tv[i] != 0 && dx <= 45 && dx >= -45 && feet >= top - 7 && feet <= top + 7)
            return i;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge Clk); #1;
   endtask

   // Reset pulse lives entirely between edges, so only an asynchronous reset acts on it.
   task automatic do_reset(string nm);
      @(negedge Clk); #1;
      Reset = 1'b1;
      model_reset();
      push(nm, cyc + 1);
      #2 Reset = 1'b0;
      step();
   endtask

   task automatic idle(string nm);
      push(nm, cyc + 1);
      step();
   endtask

   task automatic press_start();
      Start = 1'b1;
      if (m_st == 0) begin m_st = 1; m_up = 0; end
      push("start", cyc + 1);
      step();
      Start = 1'b0;
   endtask

   task automatic press_ack();
      Ack = 1'b1;
      if (m_st == 3) begin
         m_st = 0; m_y = 400; m_scroll = 0; m_score = 0; m_mid = 0;
      end
      push("ack", cyc + 1);
      step();
      Ack = 1'b0;
   endtask

   task automatic write_plat(int i, int x, int y, int v);
      tbl.plat_we = 1'b1; tbl.plat_idx = 2'(i);
      tbl.plat_x = 16'(x); tbl.plat_y = 16'(y); tbl.plat_valid = 1'(v);
      push("write", cyc + 1);
      step();
      tbl.plat_we = 1'b0;
      tx[i] = x; ty[i] = y; tv[i] = v;
   endtask

   task automatic tick(int spd, int busy_tick = -1, int wr_at = -1, int rst_at = -1);
      int k = -1;
      bit scan = 1'b0;
      speed = 4'(spd);
      frame_tick = 1'b1;
      if (m_st == 1) begin
         m_up += spd;
         m_score = (m_score + spd > 65535) ? 65535 : m_score + spd;
         if (m_y <= 275) begin
            m_scroll = (m_scroll + spd > 65535) ? 65535 : m_scroll + spd;
            m_mid = 1;
         end else begin
            m_y -= spd; m_mid = 0;
         end
         if (m_up >= 120) begin m_st = 2; m_up = 0; end
      end else if (m_st == 2) begin
         m_y += spd;
         if (m_y + 13 > 515) m_st = 3;
         else begin m_busy = 1; scan = 1'b1; k = first_hit(); end
      end
      push("tick", cyc + 1);
      step();
      frame_tick = 1'b0;
      if (scan) begin
         for (int c = 0; c < NP; c++) begin
            if (c == rst_at) begin do_reset("rst_mid_scan"); return; end
            if (c == busy_tick) frame_tick = 1'b1;
            if (c == wr_at) begin
               tbl.plat_we = 1'b1; tbl.plat_idx = 2'(c); tbl.plat_valid = 1'b0;
            end
            if (c == k || c == NP - 1) begin
               m_busy = 0;
               if (k >= 0) begin m_st = 1; m_hit = k; m_up = 0; end
            end
            push("scan", cyc + 1);
            step();
            frame_tick = 1'b0;
            if (c == wr_at) begin tbl.plat_we = 1'b0; tv[c] = 0; end
            if (m_busy == 0) break;
         end
      end
   endtask

   task automatic ticks_while(int st, int max_n);
      for (int n = 0; n < max_n && m_st == st; n++) tick(4);
   endtask

   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   initial forever begin
      @(negedge Clk);
      while (sb.size() > 0 && sb[0].stamp <= cyc) begin
         ex  = sb.pop_front();
         exn = sbn.pop_front();
         n_vec++;
         got_st = {q_Done, q_Down, q_Up, q_I};
         if (ex.stamp != cyc || got_st != 4'(1 << ex.st) || doodle_y != 16'(ex.y)
             || scroll != 16'(ex.scr) || score != 16'(ex.sco) || is_in_middle != 1'(ex.mid)
             || busy != 1'(ex.busy) || hit_idx != 2'(ex.hit)) begin
            n_bad++;
            $display("FAIL %s cyc=%0d due=%0d: got st=%b y=%0d scroll=%0d score=%0d mid=%0b busy=%0b hit=%0d, want st=%b y=%0d scroll=%0d score=%0d mid=%0d busy=%0d hit=%0d",
                     exn, cyc, ex.stamp, got_st, doodle_y, scroll, score, is_in_middle, busy, hit_idx,
                     4'(1 << ex.st), ex.y, ex.scr, ex.sco, ex.mid, ex.busy, ex.hit);
         end
      end
   end

   initial begin
      int r;
      tbl.plat_we = 1'b0; tbl.plat_idx = '0; tbl.plat_x = '0; tbl.plat_y = '0; tbl.plat_valid = 1'b0;
      for (int i = 0; i < NP; i++) begin tx[i] = 0; ty[i] = 0; end
      model_reset();
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;

      // Reset state, ignored inputs in I, then a plain jump to the floor
      do_reset("reset");
      repeat (3) tick(4);
      press_ack();
      press_start();
      repeat (30) tick(4);
      press_start();
      repeat (56) tick(4);
      press_ack();

      // Landing on platform 2 at y=407
      doodle_x = 16'd300;
      write_plat(2, 300, 420, 1);
      press_start();
      repeat (30) tick(4);
      repeat (29) tick(4);
      tick(11);

      // Next jump crosses the middle line and scrolls
      write_plat(0, 300, 393, 1);
      repeat (30) tick(4);
      ticks_while(2, 120);
      repeat (30) tick(4);

      // Priority between two hitting entries
      do_reset("reset2");
      doodle_x = 16'd300;
      press_start();
      repeat (30) tick(4);
      write_plat(1, 300, 297, 1);
      write_plat(3, 300, 297, 1);
      tick(4);

      // Miss on |dx| with a tick landing during the scan
      repeat (30) tick(4);
      doodle_x = 16'd400;
      write_plat(0, 300, m_y + 17 - m_scroll, 1);
      tick(4, 1, -1, -1);

      // Entry 3 rewritten in the cycle it is compared
      doodle_x = 16'd300;
      write_plat(0, 300, 0, 0);
      write_plat(1, 300, 0, 0);
      write_plat(3, 300, m_y + 17 - m_scroll, 1);
      tick(4, -1, 3, -1);

      // Reset mid-scan, then prove the table was invalidated
      ticks_while(1, 200);
      write_plat(3, 300, 297, 1);
      tick(4, -1, -1, 1);
      press_start();
      repeat (30) tick(4);
      tick(4);

      // Random play
      do_reset("reset3");
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 8)
            write_plat(int'($urandom_range(0, NP - 1)), 260 + int'($urandom_range(0, 80)),
                       m_y + 13 + int'($urandom_range(0, 30)) - m_scroll, int'($urandom_range(0, 1)));
         else if (r < 12) doodle_x = 16'(250 + $urandom_range(0, 100));
         else if (r < 16) press_start();
         else if (r < 20) press_ack();
         else if (r < 23) idle("idle");
         else tick(int'($urandom_range(0, 15)));
      end

      repeat (3) @(posedge Clk);
      if (sb.size() != 0) begin
         n_bad += sb.size();
         $display("FAIL drain: %0d expected snapshots never compared", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
